// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side arbiters: FSM state encoding.
package fifo_pkg;

  localparam int ST_W = 1;

  localparam logic [ST_W-1:0] ST_IDLE  = 1'b0;
  localparam logic [ST_W-1:0] ST_BURST = 1'b1;

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: first set request at or after last+1, wrapping.
module fifo_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  winner
);

  logic [ID_W-1:0]  cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // Offset gi+1 from last, so the previous owner is considered last.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_off
    assign cand[gi] = ID_W'((int'(last) + gi + 1) % N_REQ);
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    any    = |hit;
    winner = cand[0];
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) winner = cand[k];
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin, burst-limited sharing of one FIFO pop port among N_REQ consumers.
module fifo_rd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [N_REQ-1:0] req,
  input  logic             empty,
  output logic             pop,
  output logic [N_REQ-1:0] gnt,
  output logic             rd_valid,
  output logic [ID_W-1:0]  rd_id
);
  import fifo_pkg::*;

  if (N_REQ < 2) begin : g_bad_nreq
    $error("fifo_rd_arbiter: N_REQ must be >= 2");
  end
  if (BURST_MAX < 1) begin : g_bad_burst
    $error("fifo_rd_arbiter: BURST_MAX must be >= 1");
  end

  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rd_valid_q;
  logic [ID_W-1:0]  rd_id_q;
  logic             pick_any;
  logic [ID_W-1:0]  pick_winner;
  logic             pop_w;

  fifo_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Gated by empty directly so a pop can never be issued against an empty FIFO.
  assign pop_w = (state_q == ST_BURST) & req[owner_q] & ~empty;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty && pick_any) begin
          state_d = ST_BURST;
          owner_d = pick_winner;
          last_d  = pick_winner;
          cnt_d   = '0;
          gnt_d   = N_REQ'(1) << pick_winner;
        end
      end
      ST_BURST: begin
        if (pop_w) cnt_d = cnt_q + 1'b1;
        if (!req[owner_q] || empty || (pop_w && cnt_q == CNT_LAST)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= pop_w;
      if (pop_w) rd_id_q <= owner_q;
    end
  end

  assign pop      = pop_w;
  assign gnt      = gnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomized bench for fifo_rd_arbiter against a behavioural grant/burst model.
module tb_fifo_rd_arbiter;
  localparam int N  = 4;
  localparam int B  = 4;
  localparam int IW = $clog2(N);
  localparam int STARVE_BOUND = (N - 1) * (B + 1);

  logic          clk = 1'b0;
  logic          arst;
  logic [N-1:0]  req;
  logic          empty;
  logic          pop;
  logic [N-1:0]  gnt;
  logic          rd_valid;
  logic [IW-1:0] rd_id;

  fifo_rd_arbiter #(.N_REQ(N), .BURST_MAX(B)) dut (
    .clk(clk), .arst(arst), .req(req), .empty(empty),
    .pop(pop), .gnt(gnt), .rd_valid(rd_valid), .rd_id(rd_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: owner = -1 when nobody holds the port
  int m_owner, m_last, m_pops, m_rdid;
  bit m_rdv;
  int run_len;
  bit fair_on;
  int waitc [N];
  bit waiting [N];
  logic [N-1:0] prev_gnt;
  int grants [$];
  int fifo_words;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_pops = 0; m_rdv = 0; m_rdid = 0;
    run_len = 0; prev_gnt = '0;
    for (int i = 0; i < N; i++) begin waiting[i] = 0; waitc[i] = 0; end
  endtask

  // Called at posedge+1; applies inputs, checks outputs, advances model one edge.
  task automatic step(input logic [N-1:0] r, input logic e);
    logic         exp_pop;
    logic [N-1:0] exp_gnt;
    int           w;
    req = r; empty = e;
    #1;
    exp_pop = 1'b0;
    if (m_owner >= 0) exp_pop = r[m_owner] & ~e;
    exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check_val("pop", pop, exp_pop);
    check_val("gnt", gnt, exp_gnt);
    check_val("rd_valid", rd_valid, m_rdv);
    if (m_rdv) check_val("rd_id", rd_id, m_rdid);
    check_val("pop_while_empty", pop & empty, 0);
    check_val("gnt_onehot0", $onehot0(gnt), 1);
    if (pop) run_len++;
    else begin
      if (run_len > 0) check_val("burst_len_ok", run_len <= B, 1);
      run_len = 0;
    end
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) grants.push_back(i);
    end
    prev_gnt = gnt;
    // Wait is measured to the cycle gnt appears, one after the IDLE decision.
    for (int i = 0; i < N; i++) begin
      if (fair_on && r[i]) begin
        if (gnt[i]) begin
          if (waiting[i]) check_val("starve_ok", waitc[i] <= STARVE_BOUND + 1, 1);
          waiting[i] = 0;
        end else if (waiting[i]) waitc[i]++;
        else if (m_owner < 0) begin waiting[i] = 1; waitc[i] = 0; end
      end else waiting[i] = 0;
    end
    m_rdv = exp_pop;
    if (exp_pop) m_rdid = m_owner;
    if (m_owner < 0) begin
      w = rr_pick(r, m_last);
      if (!e && w >= 0) begin m_owner = w; m_last = w; m_pops = 0; end
    end else begin
      if (exp_pop) m_pops++;
      if (!r[m_owner] || e || (exp_pop && m_pops == B)) m_owner = -1;
    end
    if (exp_pop && fifo_words > 0) fifo_words--;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    check_val("rst_pop", pop, 0);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_rd_valid", rd_valid, 0);
    check_val("rst_rd_id", rd_id, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    model_reset();
    grants.delete();
  endtask

  logic [N-1:0] rq;

  initial begin
    fair_on = 0; fifo_words = 0;
    req = '0; empty = 1'b1; arst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Reset mid-burst, then req[0] must win first
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    do_reset();
    step(4'b1001, 1'b0);
    check_val("rst_first_gnt", gnt, 4'b0001);
    $display("reset test: first grant after reset gnt=%b", gnt);

    // Single requester: 4 pops, bubble, regrant
    do_reset();
    for (int c = 0; c < 16; c++) step(4'b0100, 1'b0);
    $display("single requester: done");

    // Round-robin with all requesting
    do_reset();
    for (int c = 0; c < 28; c++) step(4'b1111, 1'b0);
    check_val("rr_count", grants.size() >= 5, 1);
    if (grants.size() >= 5) begin
      check_val("rr_order0", grants[0], 0);
      check_val("rr_order1", grants[1], 1);
      check_val("rr_order2", grants[2], 2);
      check_val("rr_order3", grants[3], 3);
      check_val("rr_order4", grants[4], 0);
    end
    $display("round robin: %0d grants observed", grants.size());

    // Empty stall driven by a tiny FIFO occupancy model
    do_reset();
    fifo_words = 2;
    for (int c = 0; c < 8; c++) step(4'b0010, fifo_words == 0);
    check_val("stall_words_left", fifo_words, 0);
    fifo_words = 1;
    for (int c = 0; c < 5; c++) step(4'b0010, fifo_words == 0);
    check_val("stall_one_more", fifo_words, 0);
    $display("empty stall: done");

    // Early release by owner 3, then consumer 1 takes over
    do_reset();
    step(4'b1000, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    check_val("early_rel_gnt", gnt, 4'b0010);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    $display("early release: gnt=%b rd_id=%0d", gnt, rd_id);

    // Random req/empty
    do_reset();
    for (int c = 0; c < 5000; c++) step(N'($urandom), $urandom_range(0, 3) == 0);
    $display("random phase: total=%0d", total);

    // Fairness: requesters hold until granted, FIFO never empty
    do_reset();
    fair_on = 1;
    rq = '0;
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i] && m_owner != i) rq[i] = 1'b1;
        else if (rq[i]) rq[i] = ($urandom_range(0, 3) != 0);
        else rq[i] = $urandom_range(0, 1) == 1;
      end
      step(rq, 1'b0);
    end
    fair_on = 0;
    $display("fairness phase: total=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
